// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - weight register file filled by a handshake-driven load sequencer
// The load writes DEPTH words in order. The MLP datapath reads the file combinationally at any time.
module weight_loader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 14,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic                wr_en;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign wr_en = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (wr_en && (wr_ptr == LAST_PTR)) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // The pointer parks on the last entry once it is written; the next start rewinds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            wr_ptr <= '0;
            count  <= '0;
          end
        end
        LOAD: begin
          if (wr_en) begin
            count <= count + 1'b1;
            if (wr_ptr != LAST_PTR) wr_ptr <= wr_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Addresses beyond the populated entries read as zero.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < DEPTH_C) rd_data = mem[rd_addr];
  end

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - randomized self-checking bench for weight_loader against a behavioural model
module tb_weight_loader;

  localparam int DW = 16;
  localparam int DEPTH = 14;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [AW:0]   count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  weight_loader #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural model: a load accepts every valid word until DEPTH words have arrived.
  bit          m_active;
  bit          m_done;
  int          m_cnt;
  logic [15:0] m_mem [DEPTH];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_cnt    <= 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else if (m_active) begin
      if (in_valid) begin
        m_mem[m_cnt] <= in_data;
        m_cnt        <= m_cnt + 1;
        if (m_cnt == DEPTH - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_done   <= 1'b0;
      m_cnt    <= 0;
    end
  end

  function automatic logic [15:0] model_rd(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? m_mem[a] : 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("model_in_ready", in_ready, m_active);
      chk("model_busy", busy, m_active);
      chk("model_done", done, m_done);
      chk("model_count", count, m_cnt);
      chk("model_rd_data", rd_data, model_rd(rd_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readback(input logic [15:0] base);
    for (int k = 0; k < 16; k++) begin
      rd_addr = k[AW-1:0];
      #1;
      chk("readback", rd_data, (k < DEPTH) ? base + 16'(k) : 16'h0000);
    end
  endtask

  // mode 0: valid held high, 1: valid toggles, 2: random valid and stray starts
  task automatic do_load(input logic [15:0] base, input int mode, input bit poke,
                         input bit watch3, input logic [15:0] old3, output int edges);
    int n;
    bit tog;
    bit hit3;
    start    = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    edges = 1;
    n     = 0;
    tog   = 1'b0;
    while (n < DEPTH && edges < 400) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       begin in_valid = tog; tog = ~tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = base + 16'(n);
      start   = (poke && n == 7) || (mode == 2 && $urandom_range(0, 7) == 0);
      rd_addr = watch3 ? 4'd3 : 4'($urandom_range(0, 15));
      hit3    = watch3 && in_valid && n == 3;
      if (hit3) begin
        #1;
        chk("same_cycle_old", rd_data, old3);
      end
      tick();
      edges++;
      if (hit3) chk("next_cycle_new", rd_data, base + 16'd3);
      if (in_valid) n++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("load_handshakes", n, DEPTH);
    chk("load_done", done, 1);
    chk("load_busy", busy, 0);
    chk("load_count", count, DEPTH);
  endtask

  initial begin
    int e;
    logic [15:0] rb;

    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Start is raised in the first cycle after reset release.
    do_load(16'h0001, 0, 1'b0, 1'b0, 16'h0, e);
    chk("done_latency", e, DEPTH + 1);
    readback(16'h0001);
    repeat (3) tick();
    chk("done_holds", done, 1);

    do_load(16'h0200, 1, 1'b0, 1'b0, 16'h0, e);
    chk("stall_latency", e, 2 * DEPTH + 1);
    readback(16'h0200);

    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    repeat (3) begin
      tick();
      chk("done_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    readback(16'h0200);

    do_load(16'hA000, 0, 1'b1, 1'b0, 16'h0, e);
    chk("poke_latency", e, DEPTH + 1);
    readback(16'hA000);

    do_load(16'hB000, 0, 1'b0, 1'b1, 16'hA003, e);
    readback(16'hB000);
    rd_addr = 4'd14;
    #1;
    chk("rd_addr_14", rd_data, 0);
    rd_addr = 4'd15;
    #1;
    chk("rd_addr_15", rd_data, 0);

    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 16'hC000 + 16'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_reset_count", count, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_in_ready", in_ready, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_count", count, 0);
    for (int k = 0; k < 16; k++) begin
      rd_addr = k[AW-1:0];
      #1;
      chk("async_rd_zero", rd_data, 0);
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    for (int r = 0; r < 4; r++) begin
      rb = 16'($urandom);
      do_load(rb, 2, 1'b0, 1'b0, 16'h0, e);
      readback(rb);
      repeat ($urandom_range(0, 3)) tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter DATA_W, default 16, width of one weight word.
REQ-002 Parameter DEPTH, default 14, number of weight entries held.
REQ-003 Parameter ADDR_W, default 4, address width, SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a full load at entry 0.
REQ-007 in_valid  input  1  producer has a weight word on in_data.
REQ-008 in_data  input  DATA_W  weight word to store.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 rd_addr  input  ADDR_W  read address from the MLP datapath.
REQ-011 rd_data  output  DATA_W  combinational read of mem[rd_addr].
REQ-012 busy  output  1  high while in LOAD.
REQ-013 done  output  1  high while in DONE, meaning all DEPTH entries are written.
REQ-014 count  output  ADDR_W+1  number of words accepted in the current load.

Function
REQ-015 Internal storage SHALL be DEPTH x DATA_W registers with one write port (loader) and one combinational read port.
REQ-016 The FSM SHALL have states IDLE, LOAD, and DONE, encoded as registered state.
REQ-017 IDLE: in_ready=0, busy=0, done=0; start=1 -> LOAD with wr_ptr=0 and count=0 on the next edge.
REQ-018 LOAD: in_ready=1, busy=1.
REQ-019 In LOAD, a handshake (in_valid & in_ready) SHALL write in_data to mem[wr_ptr], then increment wr_ptr and count.
REQ-020 In LOAD, a handshake with wr_ptr==DEPTH-1 SHALL write the last entry and transition to DONE on the same edge; count becomes DEPTH.
REQ-021 DONE: in_ready=0, busy=0, done=1; count holds DEPTH.
REQ-022 In DONE, start=1 SHALL return to LOAD with wr_ptr=0 and count=0, without clearing memory.
REQ-023 start asserted while in LOAD SHALL be ignored; the load continues uninterrupted.
REQ-024 in_valid while in_ready=0 SHALL be ignored; no write, no pointer change.
REQ-025 in_valid low in LOAD SHALL stall the load indefinitely; no timeout.
REQ-026 The write pointer SHALL never exceed DEPTH-1; no wrap-around inside a load.
REQ-027 Write-to-read latency SHALL be one cycle.
REQ-028 A same-cycle read of the address being written SHALL return the old value; the new value appears from the next cycle.
REQ-029 rd_addr >= DEPTH SHALL return rd_data = 0.
REQ-030 rd_data SHALL be readable in every state, including during LOAD.
REQ-031 A load SHALL take exactly DEPTH handshakes.
REQ-032 With in_valid held high, done SHALL assert DEPTH+1 cycles after the start cycle.

Reset
REQ-033 reset=1 SHALL asynchronously force state=IDLE, wr_ptr=0, count=0, in_ready=0, busy=0, done=0.
REQ-034 reset SHALL asynchronously clear all DEPTH memory entries to 0, so rd_data=0 for every address.
REQ-035 reset asserted mid-LOAD SHALL abandon the load; after release the block stays in IDLE until start.
REQ-036 start sampled in the first edge after reset release SHALL be honoured normally.

Verification
REQ-037 Full load: start, then 14 words 0x0001..0x000E with in_valid held high -> done=1 at cycle 15; count=14; rd_addr k returns k+1 for k=0..13.
REQ-038 Stalled load: in_valid toggles 1/0 over 14 words -> done asserts only after the 14th handshake; busy=1 throughout; no extra writes.
REQ-039 Reload and ignored input:
- in DONE, drive in_valid=1, in_data=0xFFFF -> memory unchanged, in_ready=0.
- then start and reload 0xA000+k -> rd_data reflects the new values.
REQ-040 Reset mid-load: after 5 words, pulse reset asynchronously -> outputs cleared immediately; all entries read 0; state IDLE.
REQ-041 Boundary reads:
- rd_addr=14 and rd_addr=15 -> rd_data=0.
- read of mem[3] in the same cycle as its write -> old value, then new value one cycle later.
REQ-042 start during LOAD at word 7 -> ignored; the load completes with count=14 and contents unchanged from the expected data.
